alu_pg_seq: RTL and testbench
=============================

# alu_pg_seq

Parametrised, power-gated sequential ALU for the datapath power domain. Accepts one operation per valid/ready handshake, captures operands at acceptance, executes single-cycle logic/arith ops, a fixed-latency multiply and an iterative restoring divide, and holds the result until the consumer takes it. When the domain is powered down or isolated, the block aborts any in-flight op and drives a programmable clamp value.

## Interface
- WIDTH, 16: operand/result width; power of two, ≥4.
- MUL_CYCLES, 4: multiply latency in cycles; ≥1.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pwr_en  in  1  domain power enable; 0 = powered down.
- iso_en  in  1  isolation enable; 1 = outputs clamped.
- clamp_value  in  WIDTH  value loaded into result while gated/isolated.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; = (state==IDLE) & pwr_en & !iso_en.
- opcode  in  4  operation select.
- a, b  in  WIDTH  operands; sampled only on acceptance.
- out_valid  out  1  result/err valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- err  out  1  registered: illegal opcode or divide by zero.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept = in_valid & in_ready at a clock edge; a, b, opcode captured in internal registers; later changes on a/b ignored.
- Opcodes: 0000 a+b; 0001 a−b; 0010 and; 0011 or; 0100 xor; 0101 nor; 0110 a>>b[log2(WIDTH)−1:0] logical; 0111 xnor; 1000 a*b low WIDTH bits; 1001 a/b unsigned quotient; 1010 a%b (macro-gated); 1011 a<<b[log2(WIDTH)−1:0]. Add/sub/mul wrap modulo 2^WIDTH, no carry/overflow output.
- Single-cycle ops and illegal opcodes: result, err written at accept edge; IDLE→DONE.
- Illegal opcode: result=0, err=1.
- MUL: IDLE→MUL; counter 0..MUL_CYCLES−1; result written on final count; MUL→DONE.
- DIV/REM with b≠0: IDLE→DIV; restoring divider, one quotient bit per cycle, WIDTH iterations; MSB first; result = quotient (1001) or remainder (1010); DIV→DONE.
- DIV/REM with b==0: no iteration; result = all-ones (1001) or a (1010), err=1; IDLE→DONE at accept edge.
- DONE: out_valid=1, result/err stable; on out_valid & out_ready → IDLE. in_ready=0 in DONE, MUL, DIV.
- Gating: at any edge with !pwr_en | iso_en: state→IDLE, counters/divider cleared, out_valid→0, err→0, result→clamp_value. Highest priority after rst; pending result is discarded, not replayed.

## Timing
- Reset (async): state IDLE, result 0, err 0, out_valid 0, busy 0; in_ready follows its combinational equation (1 if pwr_en & !iso_en).
- Latency from accept edge to out_valid high: 1 cycle (logic/illegal/div-by-zero), MUL_CYCLES (mul), WIDTH (div/rem).
- Max throughput, single-cycle ops with out_ready held 1: one op per 2 cycles (accept, DONE).
- out_ready low: DONE held indefinitely, no loss.
- Gating asserted in same cycle as in_valid: no accept (in_ready=0).
- Gating deasserted: in_ready=1 the same cycle; result keeps clamp_value until next op writes it.
- rst mid-operation: immediate abort to reset values.

## Configuration
- ALU_REM_EN defined: opcode 1010 returns remainder via the shared divider (remainder register retained).
- ALU_REM_EN undefined: remainder logic removed; 1010 is illegal (result 0, err 1, latency 1).

## Test plan
- Reset then pwr_en=1, iso_en=0: a=0xFFFF, b=0x0001, op 0000 → out_valid 1 cycle after accept, result 0x0000, err 0.
- op 1000, a=0x0012, b=0x0034, MUL_CYCLES=4, out_ready=1 → out_valid exactly 4 cycles after accept, result 0x03A8; a/b changed after accept have no effect.
- op 1001, a=100, b=7 → result 14 after 16 cycles; with ALU_REM_EN, op 1010 → result 2; b=0 op 1001 → 0xFFFF, err 1, 1 cycle.
- op 1111 → result 0, err 1; out_ready held 0 for 5 cycles → out_valid, result stable, in_ready 0 throughout.
- Start div, assert iso_en at cycle 5 with clamp_value=0xDEAD → next edge: busy 0, out_valid 0, result 0xDEAD; release iso_en → in_ready 1 same cycle.
- Assert rst mid-MUL → result 0, out_valid 0, busy 0 without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pg_seq.sv
// Power-gated sequential ALU with a valid/ready request and result handshake.
// Runs single-cycle logic/arith ops, a fixed-latency multiply and a restoring
// divider. Gating (pwr_en low or iso_en high) aborts work and clamps result.
// Optional feature macro: ALU_REM_EN enables opcode 1010 (remainder).
module alu_pg_seq #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_en,
  input  logic             iso_en,
  input  logic [WIDTH-1:0] clamp_value,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  localparam int unsigned ShW    = $clog2(WIDTH);
  localparam int unsigned CntMax = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  // The accept edge counts as cycle 0 for both multi-cycle ops.
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpNor = 4'b0101;
  localparam logic [3:0] OpShr = 4'b0110;
  localparam logic [3:0] OpXnr = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1000;
  localparam logic [3:0] OpDiv = 4'b1001;
`ifdef ALU_REM_EN
  localparam logic [3:0] OpRem = 4'b1010;
`endif
  localparam logic [3:0] OpShl = 4'b1011;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
`ifdef ALU_REM_EN
  logic             is_rem_q, is_rem_d;
`endif

  logic             gated;
  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] div_rem_in, div_quo_in, div_den;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_bit;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign gated     = ~pwr_en | iso_en;
  assign in_ready  = (state_q == StIdle) & ~gated;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign err       = err_q;
  assign prod      = a_q * b_q;

  // Single-cycle ops, evaluated on the live inputs for the accept edge.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (opcode)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpNor:   alu_res = ~(a | b);
      OpShr:   alu_res = a >> b[ShW-1:0];
      OpXnr:   alu_res = ~(a ^ b);
      OpShl:   alu_res = a << b[ShW-1:0];
      default: alu_legal = 1'b0;
    endcase
  end

  // One restoring-divide step; in idle it runs the first step off the raw inputs.
  always_comb begin
    div_rem_in = (state_q == StIdle) ? '0 : rem_q;
    div_quo_in = (state_q == StIdle) ? a  : quo_q;
    div_den    = (state_q == StIdle) ? b  : b_q;
    div_shift  = {div_rem_in, div_quo_in[WIDTH-1]};
    div_diff   = div_shift - {1'b0, div_den};
    div_bit    = ~div_diff[WIDTH];
    rem_step   = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_step   = {div_quo_in[WIDTH-2:0], div_bit};
  end

  // Next-state and datapath update; gating overrides everything but reset.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
`ifdef ALU_REM_EN
    is_rem_d = is_rem_q;
`endif
    if (gated) begin
      state_d  = StIdle;
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = '0;
      err_d    = 1'b0;
      result_d = clamp_value;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_d   = a;
            b_d   = b;
            cnt_d = CntW'(1);
`ifdef ALU_REM_EN
            is_rem_d = (opcode == OpRem);
`endif
            case (opcode)
              OpMul: begin
                if (MUL_CYCLES == 1) begin
                  result_d = a * b;
                  err_d    = 1'b0;
                  state_d  = StDone;
                end else begin
                  state_d = StMul;
                end
              end
              OpDiv: begin
                if (b == '0) begin
                  result_d = '1;
                  err_d    = 1'b1;
                  state_d  = StDone;
                end else begin
                  rem_d   = rem_step;
                  quo_d   = quo_step;
                  state_d = StDiv;
                end
              end
`ifdef ALU_REM_EN
              OpRem: begin
                if (b == '0) begin
                  result_d = a;
                  err_d    = 1'b1;
                  state_d  = StDone;
                end else begin
                  rem_d   = rem_step;
                  quo_d   = quo_step;
                  state_d = StDiv;
                end
              end
`endif
              default: begin
                result_d = alu_legal ? alu_res : '0;
                err_d    = ~alu_legal;
                state_d  = StDone;
              end
            endcase
          end
        end
        StMul: begin
          if (cnt_q == MulLast) begin
            result_d = prod;
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDiv: begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == DivLast) begin
`ifdef ALU_REM_EN
            result_d = is_rem_q ? rem_step : quo_step;
`else
            result_d = quo_step;
`endif
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      err_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
`ifdef ALU_REM_EN
      is_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
`ifdef ALU_REM_EN
      is_rem_q <= is_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pg_seq.sv
// Scoreboard bench for alu_pg_seq: a driver pushes model results, a negedge
// monitor pops and compares them; directed gating and reset checks are inline.
module tb_alu_pg_seq;
  localparam int W  = 16;
  localparam int MC = 4;

  logic         clk = 1'b0;
  logic         rst, pwr_en, iso_en;
  logic [W-1:0] clamp_value, a, b, result;
  logic         in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [3:0]   opcode;

  alu_pg_seq #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .pwr_en(pwr_en), .iso_en(iso_en),
    .clamp_value(clamp_value), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   rand_ready = 1'b0;
  bit   seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    int   sh;
    sh    = int'(y) % W;
    e.res = '0;
    e.err = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (op)
      4'd0:  e.res = x + y;
      4'd1:  e.res = x - y;
      4'd2:  e.res = x & y;
      4'd3:  e.res = x | y;
      4'd4:  e.res = x ^ y;
      4'd5:  e.res = ~(x | y);
      4'd6:  e.res = x >> sh;
      4'd7:  e.res = ~(x ^ y);
      4'd8:  begin e.res = x * y; e.lat = MC; end
      4'd9:  begin
        if (y == 0) begin e.res = '1; e.err = 1'b1; end
        else begin e.res = x / y; e.lat = W; end
      end
`ifdef ALU_REM_EN
      4'd10: begin
        if (y == 0) begin e.res = x; e.err = 1'b1; end
        else begin e.res = x % y; e.lat = W; end
      end
`endif
      4'd11: e.res = x << sh;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: checks every valid cycle against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (rst || !out_valid) begin
      seen = 1'b0;
    end else if (sbq.size() == 0) begin
      chk("unexpected_out_valid", 32'(out_valid), 32'd0);
    end else begin
      if (!seen) begin
        seen = 1'b1;
        chk("latency", 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
      end
      chk("result", 32'(result), 32'(sbq[0].res));
      chk("err", 32'(err), 32'(sbq[0].err));
      chk("in_ready_while_done", 32'(in_ready), 32'd0);
      if (out_ready) begin
        void'(sbq.pop_front());
        seen = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one request, wait for acceptance, optionally score it.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push);
    exp_t e;
    int   t;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    a        = x;
    b        = y;
    t        = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e     = model(op, x, y);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    opcode   = 4'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_size", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    #500000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  logic [3:0]   rop;
  logic [W-1:0] rx, ry;

  initial begin
    rst = 1'b0; pwr_en = 1'b1; iso_en = 1'b0; clamp_value = '0;
    in_valid = 1'b0; opcode = '0; a = '0; b = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed ops with out_ready always high.
    @(posedge clk); #1 out_ready = 1'b1;
    issue(4'b0000, 16'hFFFF, 16'h0001, 1'b1);
    issue(4'b1000, 16'h0012, 16'h0034, 1'b1);
    issue(4'b1001, 16'd100, 16'd7, 1'b1);
    issue(4'b1010, 16'd100, 16'd7, 1'b1);
    issue(4'b1001, 16'd100, 16'd0, 1'b1);
    issue(4'b0110, 16'h8000, 16'h0013, 1'b1);
    issue(4'b1011, 16'h0001, 16'h000F, 1'b1);
    drain();

    // Illegal opcode held in DONE while the consumer stalls.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(4'b1111, 16'h1234, 16'h5678, 1'b1);
    repeat (5) @(negedge clk);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Randomized ops with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = W'($urandom);
      ry  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(rop, rx, ry, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    // Isolation mid-divide aborts and clamps.
    issue(4'b1001, 16'd1000, 16'd3, 1'b0);
    repeat (4) @(negedge clk);
    clamp_value = 16'hDEAD;
    iso_en      = 1'b1;
    @(negedge clk);
    chk("iso_busy", 32'(busy), 32'd0);
    chk("iso_out_valid", 32'(out_valid), 32'd0);
    chk("iso_result", 32'(result), 32'hDEAD);
    chk("iso_err", 32'(err), 32'd0);
    chk("iso_in_ready", 32'(in_ready), 32'd0);
    iso_en = 1'b0;
    #1;
    chk("iso_release_in_ready", 32'(in_ready), 32'd1);
    chk("iso_release_result", 32'(result), 32'hDEAD);

    // Power-down blocks a request offered in the same cycle.
    @(negedge clk);
    clamp_value = 16'h1234;
    pwr_en      = 1'b0;
    in_valid    = 1'b1;
    opcode      = 4'b0000;
    a           = 16'd1;
    b           = 16'd2;
    #1;
    chk("pwr_off_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("pwr_off_busy", 32'(busy), 32'd0);
    chk("pwr_off_result", 32'(result), 32'h1234);
    in_valid = 1'b0;
    pwr_en   = 1'b1;

    // Asynchronous reset in the middle of a multiply.
    issue(4'b1000, 16'd3, 16'd5, 1'b0);
    @(negedge clk);
    chk("mul_busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_result", 32'(result), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b1001, 16'hFFFF, 16'h0010, 1'b1);
    issue(4'b0101, 16'h0F0F, 16'h00FF, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
